// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_if
// Purpose  : Fetch-stage bundle: imem read port, ID handshake and EXE redirect.
// Revision : 1.0
// ============================================================================
interface instr_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_rvalid;
  logic [31:0]       instruction;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              id_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              fetch_idle;

  modport master (
    output imem_req, imem_addr, instruction, instr_pc, instr_valid, fetch_idle,
    input  imem_rdata, imem_rvalid, id_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_pc, instr_valid, fetch_idle,
    output imem_rdata, imem_rvalid, id_ready, redirect, redirect_pc, halt
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : PC generation, in-order imem reads and a PC-tagged prefetch FIFO to ID.
// Revision : 1.0
// ============================================================================
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic     clk,
  input  wire logic     rst,
  instr_fetch_if.master fetch_io
);

  localparam int                c_PTR_W = $clog2(DEPTH);
  localparam int                c_CNT_W = $clog2(DEPTH) + 1;
  localparam logic [c_CNT_W:0]  c_DEPTH = (c_CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] c_ALIGN = ~(ADDR_W'(3));

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [31:0]        fifo_word_q [DEPTH];
  logic [ADDR_W-1:0]  fifo_pc_q   [DEPTH];
  logic [ADDR_W-1:0]  rq_pc_q     [DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_PTR_W-1:0] rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d;
  logic [c_CNT_W-1:0] count_q, count_d, outst_q, outst_d, disc_q, disc_d;
  logic [31:0]        instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               ivalid_q, ivalid_d;

  logic               w_req, w_pop, w_rsp, w_push;
  logic [c_CNT_W:0]   w_live;
  logic [c_CNT_W-1:0] w_cnt_after_pop;
  logic [ADDR_W-1:0]  w_rsp_pc, w_redir_pc;

  // Live work = buffered words plus in-flight requests that will not be dropped.
  assign w_live     = {1'b0, count_q} + {1'b0, outst_q} - {1'b0, disc_q};
  assign w_req      = !rst && !fetch_io.halt && !fetch_io.redirect && (w_live < c_DEPTH);
  assign w_pop      = ivalid_q && fetch_io.id_ready && !fetch_io.redirect;
  assign w_rsp      = fetch_io.imem_rvalid;
  assign w_push     = w_rsp && !fetch_io.redirect && (disc_q == '0);
  assign w_rsp_pc   = rq_pc_q[rq_rd_q];
  assign w_redir_pc = fetch_io.redirect_pc & c_ALIGN;
  assign w_cnt_after_pop = count_q - c_CNT_W'(w_pop);

  assign fetch_io.imem_req    = w_req;
  assign fetch_io.imem_addr   = pc_q;
  assign fetch_io.instruction = instr_q;
  assign fetch_io.instr_pc    = ipc_q;
  assign fetch_io.instr_valid = ivalid_q;
  assign fetch_io.fetch_idle  = (count_q == '0) && (outst_q == '0);

  always_comb begin
    pc_d     = pc_q;
    rq_wr_d  = rq_wr_q + c_PTR_W'(w_req);
    rq_rd_d  = rq_rd_q + c_PTR_W'(w_rsp);
    outst_d  = outst_q + c_CNT_W'(w_req) - c_CNT_W'(w_rsp);
    disc_d   = disc_q;
    wr_ptr_d = wr_ptr_q + c_PTR_W'(w_push);
    rd_ptr_d = rd_ptr_q + c_PTR_W'(w_pop);
    count_d  = w_cnt_after_pop + c_CNT_W'(w_push);
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    ivalid_d = 1'b0;

    if (fetch_io.redirect) begin
      pc_d = w_redir_pc;
    end else if (w_req) begin
      pc_d = pc_q + c_STEP;
    end

    // Everything still in flight after this cycle's response belongs to the old stream.
    if (fetch_io.redirect) begin
      disc_d = outst_q - c_CNT_W'(w_rsp);
    end else if (w_rsp && (disc_q != '0)) begin
      disc_d = disc_q - c_CNT_W'(1);
    end

    if (fetch_io.redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (w_push && (w_cnt_after_pop == '0)) begin
      // The incoming word becomes the head directly; its slot is not written yet.
      ivalid_d = 1'b1;
      instr_d  = fetch_io.imem_rdata;
      ipc_d    = w_rsp_pc;
    end else if (count_d != '0) begin
      ivalid_d = 1'b1;
      instr_d  = fifo_word_q[rd_ptr_d];
      ipc_d    = fifo_pc_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rq_wr_q  <= '0;
      rq_rd_q  <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      disc_q   <= '0;
      instr_q  <= '0;
      ipc_q    <= '0;
      ivalid_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rq_wr_q  <= rq_wr_d;
      rq_rd_q  <= rq_rd_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      disc_q   <= disc_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      ivalid_q <= ivalid_d;
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (w_req) begin
      rq_pc_q[rq_wr_q] <= pc_q;
    end
    if (w_push) begin
      fifo_word_q[wr_ptr_q] <= fetch_io.imem_rdata;
      fifo_pc_q[wr_ptr_q]   <= w_rsp_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Directed and randomized bench for instr_fetch with a stream-level model.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch;

  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_io (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ins_t;

  int checks = 0;
  int errors = 0;

  // Model: requests awaiting a memory response, and words ID should see, in order.
  req_t        pend[$];
  ins_t        vis[$];
  int          cyc = 0;
  int          epoch = 0;
  int          live = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_extra = 0;
  logic [31:0] exp_pc = RESET_PC;

  // DUT observations collected per test.
  logic [31:0] req_addrs[$];
  int          req_cycs[$];
  logic [31:0] deliv_pc[$];
  logic [31:0] deliv_w[$];
  int          deliv_cycs[$];
  logic        last_coinc, last_valid, last_idle;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_FFFF;
    if (a == 32'h4) return 32'h0200_EEEE;
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    req_addrs.delete();
    req_cycs.delete();
    deliv_pc.delete();
    deliv_w.delete();
    deliv_cycs.delete();
  endtask

  task automatic model_reset();
    pend.delete();
    vis.delete();
    live     = 0;
    epoch++;
    exp_pc   = RESET_PC;
    last_due = 0;
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic step(input logic rdy, input logic hlt, input logic redir, input logic [31:0] rpc);
    req_t r;
    logic rv;
    logic ereq;
    int   due;
    bus.id_ready    = rdy;
    bus.halt        = hlt;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    rv = 1'b0;
    if (pend.size() > 0) rv = (pend[0].due <= cyc);
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? memword(pend[0].pc) : $urandom;
    @(negedge clk);

    ereq = !hlt && !redir && (live < DEPTH);
    chk("imem_req", bus.imem_req, ereq);
    if (ereq) chk("imem_addr", bus.imem_addr, exp_pc);
    chk("instr_valid", bus.instr_valid, vis.size() > 0);
    if (vis.size() > 0) begin
      chk("instr_pc", bus.instr_pc, vis[0].pc);
      chk("instruction", bus.instruction, vis[0].word);
    end
    chk("fetch_idle", bus.fetch_idle, (vis.size() == 0) && (pend.size() == 0));

    if (bus.imem_req) begin
      req_addrs.push_back(bus.imem_addr);
      req_cycs.push_back(cyc);
    end
    if (bus.instr_valid && rdy && !redir) begin
      deliv_pc.push_back(bus.instr_pc);
      deliv_w.push_back(bus.instruction);
      deliv_cycs.push_back(cyc);
    end
    last_coinc = rv && bus.instr_valid && rdy;
    last_valid = bus.instr_valid;
    last_idle  = bus.fetch_idle;

    if ((vis.size() > 0) && rdy && !redir) begin
      void'(vis.pop_front());
      live--;
    end
    if (rv) begin
      r = pend.pop_front();
      if (!redir && (r.epoch == epoch)) vis.push_back('{r.pc, memword(r.pc)});
    end
    if (redir) begin
      vis.delete();
      epoch++;
      live   = 0;
      exp_pc = rpc & ~32'h3;
    end
    if (ereq) begin
      due = cyc + lat_min + int'($urandom_range(lat_extra, 0));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{exp_pc, epoch, due});
      exp_pc = exp_pc + 32'd4;
      live++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asserts reset between clock edges and checks outputs clear before any edge.
  task automatic apply_reset();
    bus.redirect    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.halt        = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", bus.instr_valid, 1'b0);
    chk("arst_req", bus.imem_req, 1'b0);
    chk("arst_idle", bus.fetch_idle, 1'b1);
    chk("arst_pc", bus.instr_pc, 32'h0);
    chk("arst_instr", bus.instruction, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  int          halt_cnt;
  logic [31:0] hold_pc;

  initial begin
    bus.id_ready    = 1'b0;
    bus.halt        = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_idle", bus.fetch_idle, 1'b1);
    chk("rst_instr", bus.instruction, 32'h0);
    chk("rst_pc", bus.instr_pc, 32'h0);
    rst = 1'b0;
    model_reset();

    // Single-cycle memory, ID always ready.
    lat_min = 1; lat_extra = 0;
    clear_obs();
    repeat (12) step(1'b1, 1'b0, 1'b0, '0);
    chk("t1_addr0", req_addrs[0], 32'h0);
    chk("t1_addr1", req_addrs[1], 32'h4);
    chk("t1_addr2", req_addrs[2], 32'h8);
    chk("t1_back2back", req_cycs[2] - req_cycs[0], 2);
    chk("t1_latency", deliv_cycs[0] - req_cycs[0], 2);
    chk("t1_pc0", deliv_pc[0], 32'h0);
    chk("t1_w0", deliv_w[0], 32'h0000_FFFF);
    chk("t1_pc1", deliv_pc[1], 32'h4);
    chk("t1_w1", deliv_w[1], 32'h0200_EEEE);
    chk("t1_rate", deliv_cycs[1] - deliv_cycs[0], 1);

    // ID stalled: FIFO fills, fetch stops at DEPTH requests.
    apply_reset();
    clear_obs();
    repeat (10) step(1'b0, 1'b0, 1'b0, '0);
    chk("t2_nreq", req_addrs.size(), DEPTH);
    chk("t2_last_addr", req_addrs[DEPTH-1], 32'hC);
    chk("t2_hold_pc", bus.instr_pc, 32'h0);
    clear_obs();
    repeat (12) step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) chk("t2_order", deliv_pc[i], 32'(i * 4));
    chk("t2_resume", req_addrs[0], 32'h10);

    // Redirect with two slow responses in flight; reset here from a full FIFO.
    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
    chk("t6_pre_valid", bus.instr_valid, 1'b1);
    apply_reset();
    lat_min = 3;
    clear_obs();
    repeat (2) step(1'b1, 1'b0, 1'b0, '0);
    chk("t6_restart", req_addrs[0], RESET_PC);
    chk("t3_inflight", req_addrs.size(), 2);
    step(1'b1, 1'b0, 1'b1, 32'h43);
    clear_obs();
    repeat (12) step(1'b1, 1'b0, 1'b0, '0);
    chk("t3_new_addr", req_addrs[0], 32'h40);
    chk("t3_first_pc", deliv_pc[0], 32'h40);

    // Redirect coinciding with a response and a consumed head.
    apply_reset();
    lat_min = 1;
    repeat (6) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 32'h200);
    chk("t4_coincident", last_coinc, 1'b1);
    clear_obs();
    step(1'b1, 1'b0, 1'b0, '0);
    chk("t4_flushed", last_valid, 1'b0);
    repeat (8) step(1'b1, 1'b0, 1'b0, '0);
    chk("t4_first_pc", deliv_pc[0], 32'h200);

    // Halt mid-stream, then redirect while halted.
    apply_reset();
    lat_min = 2;
    repeat (6) step(1'b1, 1'b0, 1'b0, '0);
    hold_pc = exp_pc;
    clear_obs();
    repeat (8) step(1'b1, 1'b1, 1'b0, '0);
    chk("t5_no_req", req_addrs.size(), 0);
    chk("t5_drained", deliv_pc.size() >= 2, 1'b1);
    chk("t5_idle", last_idle, 1'b1);
    clear_obs();
    repeat (4) step(1'b1, 1'b0, 1'b0, '0);
    chk("t5_resume", req_addrs[0], hold_pc);
    step(1'b1, 1'b1, 1'b1, 32'h81);
    clear_obs();
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);
    chk("t5_halt_redir", req_addrs.size(), 0);
    repeat (4) step(1'b1, 1'b0, 1'b0, '0);
    chk("t5_redir_addr", req_addrs[0], 32'h80);

    // PC wraps modulo 2^ADDR_W.
    lat_min = 1;
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9);
    clear_obs();
    repeat (6) step(1'b1, 1'b0, 1'b0, '0);
    chk("wrap_a0", req_addrs[0], 32'hFFFF_FFF8);
    chk("wrap_a2", req_addrs[2], 32'h0);
    chk("wrap_pc1", deliv_pc[1], 32'hFFFF_FFFC);

    // Randomized traffic against the model.
    halt_cnt = 0;
    for (int n = 0; n < 2000; n++) begin
      logic hlt, redir, rdy;
      if ((n % 250) == 0) begin
        lat_min   = int'($urandom_range(2, 1));
        lat_extra = int'($urandom_range(2, 0));
      end
      if (halt_cnt > 0) halt_cnt--;
      else if (($urandom % 40) == 0) halt_cnt = int'($urandom_range(8, 1));
      hlt   = (halt_cnt > 0);
      redir = (($urandom % 23) == 0);
      rdy   = (($urandom % 4) != 0);
      step(rdy, hlt, redir, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
